fwd_operand_pipe: RTL and testbench
===================================

Name: fwd_operand_pipe

Overview:
- Producer/consumer counterpart of the forwarding unit.
- Owns the ID/EX, EX/MEM and MEM/WB destination-tracking pipeline registers, and drives the forwarding request fields (rs1_EX, rs2_EX, wsel_MEM, wsel_WB, RegWr_MEM, RegWr_WB).
- Consumes ForwardA/ForwardB and muxes the forwarded EX operands.
- Detects load-use hazards and keeps a saturating forward-event counter.
- Sits in the datapath between decode, the ALU and writeback.

Parameters:
- DATA_W, 32, operand/result width
- REG_W, 5, register index width
- CNT_W, 16, forward-event counter width

Ports:
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  reset; one clock; reset is synchronous and active-low
- freeze  in  1  global pipeline hold (cache miss); all registers hold
- flush_EX  in  1  squash the instruction entering EX (branch/jump resolved)
- valid_ID  in  1  ID holds a real instruction
- rs1_ID, rs2_ID  in  REG_W  ID source registers
- rdat1_ID, rdat2_ID  in  DATA_W  register file read data
- wsel_ID  in  REG_W  ID destination register
- RegWr_ID, MemRd_ID  in  1  ID writes register / is load
- alu_result_EX  in  DATA_W  ALU result of current EX instruction
- dmem_rdata_MEM  in  DATA_W  load data returned in MEM
- ForwardA, ForwardB  in  2  forwarding unit selects
- rs1_EX, rs2_EX, wsel_MEM, wsel_WB  out  REG_W  to forwarding unit
- RegWr_MEM, RegWr_WB  out  1  to forwarding unit
- opA_EX, opB_EX  out  DATA_W  forwarded ALU operands
- wdat_WB  out  DATA_W  register file write data
- lu_stall  out  1  load-use hazard; hold PC and IF/ID
- fwd_count  out  CNT_W  saturating count of forwarded operands

Behaviour:
- Registers:
  - ID/EX: valid, rs1, rs2, rdat1, rdat2, wsel, RegWr, MemRd.
  - EX/MEM: wsel, RegWr, MemRd, alu.
  - MEM/WB: wsel, RegWr, wdat.
- Reset (nRST=0 at edge): every register and fwd_count clears to 0, so every output reads 0; lu_stall=0.
- Update priority per edge: nRST > freeze (everything holds, including fwd_count) > normal.
- Normal ID/EX load: if flush_EX or lu_stall, load a bubble (valid=0, RegWr=0, MemRd=0, other fields 0); otherwise capture the ID inputs with valid=valid_ID.
- x0 rule: captured RegWr is forced to 0 when wsel_ID=0 or valid_ID=0. The forwarding unit therefore never sees a write to x0.
- EX/MEM always captures from ID/EX; alu=alu_result_EX. MEM/WB always captures from EX/MEM; wdat = MemRd_MEM ? dmem_rdata_MEM : alu_MEM.
- Combinational outputs: rs1_EX/rs2_EX come from ID/EX; wsel/RegWr come from EX/MEM and MEM/WB; wdat_WB=MEM/WB wdat.
- Operand mux (opA_EX from ForwardA, opB_EX from ForwardB):
  - 2'b10 -> alu_MEM
  - 2'b01 -> wdat_WB
  - 2'b00 -> rdat_EX
  - 2'b11 -> rdat_EX (reserved)
  - Zero latency, pure mux.
- A load in MEM is never selected by ForwardX=10; lu_stall guarantees it.
- lu_stall = valid_EX & MemRd_EX & RegWr_EX & valid_ID & ((wsel_EX==rs1_ID) | (wsel_EX==rs2_ID)). Combinational, asserted exactly one cycle per dependent load because a bubble follows.
- lu_stall is suppressed (0) while freeze=1. flush_EX and lu_stall together give a single bubble.
- fwd_count increments each unfrozen cycle by (valid_EX & ForwardA!=0 & ForwardA!=3) + (same for B), adding 0..2. It saturates at all-ones and never wraps.
- Reset mid-operation: in-flight instructions are discarded; no partial state survives.

Test Plan:
- Reset: nRST=0 for 2 cycles with random inputs -> all outputs 0, fwd_count=0. After release, first instr wsel_ID=5 RegWr_ID=1 -> one cycle later rs1_EX from ID, two cycles later wsel_MEM=5, RegWr_MEM=1.
- EX->EX forward: add x3 (alu=0x10), then ID/EX rdat1=0xDEAD, ForwardA=10 -> opA_EX=0x10; ForwardA=01 -> opA_EX=wdat_WB; ForwardA=11 -> opA_EX=0xDEAD. fwd_count counts 1 each for the 10 and 01 cycles, nothing for 11.
- Load-use: lw x7 in EX, ID rs2_ID=7 -> lu_stall=1 for exactly 1 cycle and a bubble enters EX. Two cycles later wdat_WB=dmem_rdata value 0xCAFE.
- x0 and flush: wsel_ID=0 RegWr_ID=1 -> RegWr_MEM=0. With flush_EX=1, the next EX has valid=0 and RegWr_MEM=0 downstream. flush_EX together with lu_stall gives one bubble.
- Freeze: freeze=1 for 3 cycles mid-stream -> all pipeline outputs and fwd_count are unchanged, and lu_stall=0 even with a dependent load present.
- Saturation: preload via 2^CNT_W-1 forward events with CNT_W=4, both Forward=10 -> fwd_count sticks at 15.

Source files
------------

// File: rtl/fwd_operand_pipe.sv
// fwd_operand_pipe: destination-tracking pipeline registers (ID/EX, EX/MEM,
// MEM/WB) feeding the forwarding unit, the forwarded EX operand muxes,
// load-use hazard detection and a saturating forward-event counter.
module fwd_operand_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              freeze,
    input  logic              flush_EX,
    input  logic              valid_ID,
    input  logic [REG_W-1:0]  rs1_ID,
    input  logic [REG_W-1:0]  rs2_ID,
    input  logic [DATA_W-1:0] rdat1_ID,
    input  logic [DATA_W-1:0] rdat2_ID,
    input  logic [REG_W-1:0]  wsel_ID,
    input  logic              RegWr_ID,
    input  logic              MemRd_ID,
    input  logic [DATA_W-1:0] alu_result_EX,
    input  logic [DATA_W-1:0] dmem_rdata_MEM,
    input  logic [1:0]        ForwardA,
    input  logic [1:0]        ForwardB,
    output logic [REG_W-1:0]  rs1_EX,
    output logic [REG_W-1:0]  rs2_EX,
    output logic [REG_W-1:0]  wsel_MEM,
    output logic [REG_W-1:0]  wsel_WB,
    output logic              RegWr_MEM,
    output logic              RegWr_WB,
    output logic [DATA_W-1:0] opA_EX,
    output logic [DATA_W-1:0] opB_EX,
    output logic [DATA_W-1:0] wdat_WB,
    output logic              lu_stall,
    output logic [CNT_W-1:0]  fwd_count
);

    // ID/EX stage
    logic              valid_ex_q, valid_ex_d;
    logic [REG_W-1:0]  rs1_ex_q, rs1_ex_d;
    logic [REG_W-1:0]  rs2_ex_q, rs2_ex_d;
    logic [DATA_W-1:0] rdat1_ex_q, rdat1_ex_d;
    logic [DATA_W-1:0] rdat2_ex_q, rdat2_ex_d;
    logic [REG_W-1:0]  wsel_ex_q, wsel_ex_d;
    logic              regwr_ex_q, regwr_ex_d;
    logic              memrd_ex_q, memrd_ex_d;

    // EX/MEM stage
    logic [REG_W-1:0]  wsel_mem_q, wsel_mem_d;
    logic              regwr_mem_q, regwr_mem_d;
    logic              memrd_mem_q, memrd_mem_d;
    logic [DATA_W-1:0] alu_mem_q, alu_mem_d;

    // MEM/WB stage
    logic [REG_W-1:0]  wsel_wb_q, wsel_wb_d;
    logic              regwr_wb_q, regwr_wb_d;
    logic [DATA_W-1:0] wdat_wb_q, wdat_wb_d;

    logic [CNT_W-1:0]  fwd_count_q, fwd_count_d;

    logic              stall;
    logic              fwd_a_hit;
    logic              fwd_b_hit;
    logic [1:0]        fwd_inc;
    logic [CNT_W:0]    fwd_sum;

    // Operand select: 10 takes the EX/MEM ALU result, 01 the writeback data,
    // 00 and the reserved 11 keep the register file value.
    function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0]        sel,
                                                  input logic [DATA_W-1:0] alu_mem,
                                                  input logic [DATA_W-1:0] wdat_wb,
                                                  input logic [DATA_W-1:0] rdat);
        case (sel)
            2'b10:   fwd_mux = alu_mem;
            2'b01:   fwd_mux = wdat_wb;
            default: fwd_mux = rdat;
        endcase
    endfunction

    // Load-use hazard, forwarded operands and counter increment (all combinational)
    always_comb begin
        stall = ~freeze & valid_ex_q & memrd_ex_q & regwr_ex_q & valid_ID &
                ((wsel_ex_q == rs1_ID) | (wsel_ex_q == rs2_ID));
        opA_EX    = fwd_mux(ForwardA, alu_mem_q, wdat_wb_q, rdat1_ex_q);
        opB_EX    = fwd_mux(ForwardB, alu_mem_q, wdat_wb_q, rdat2_ex_q);
        fwd_a_hit = valid_ex_q & ((ForwardA == 2'b10) | (ForwardA == 2'b01));
        fwd_b_hit = valid_ex_q & ((ForwardB == 2'b10) | (ForwardB == 2'b01));
        fwd_inc   = {1'b0, fwd_a_hit} + {1'b0, fwd_b_hit};
        fwd_sum   = {1'b0, fwd_count_q} + {{(CNT_W-1){1'b0}}, fwd_inc};
    end

    // Next-state for all pipeline registers; freeze holds everything
    always_comb begin
        valid_ex_d  = valid_ex_q;
        rs1_ex_d    = rs1_ex_q;
        rs2_ex_d    = rs2_ex_q;
        rdat1_ex_d  = rdat1_ex_q;
        rdat2_ex_d  = rdat2_ex_q;
        wsel_ex_d   = wsel_ex_q;
        regwr_ex_d  = regwr_ex_q;
        memrd_ex_d  = memrd_ex_q;
        wsel_mem_d  = wsel_mem_q;
        regwr_mem_d = regwr_mem_q;
        memrd_mem_d = memrd_mem_q;
        alu_mem_d   = alu_mem_q;
        wsel_wb_d   = wsel_wb_q;
        regwr_wb_d  = regwr_wb_q;
        wdat_wb_d   = wdat_wb_q;
        fwd_count_d = fwd_count_q;
        if (!freeze) begin
            if (flush_EX || stall) begin
                // A squash and a load-use stall collapse into one bubble
                valid_ex_d = 1'b0;
                rs1_ex_d   = '0;
                rs2_ex_d   = '0;
                rdat1_ex_d = '0;
                rdat2_ex_d = '0;
                wsel_ex_d  = '0;
                regwr_ex_d = 1'b0;
                memrd_ex_d = 1'b0;
            end else begin
                valid_ex_d = valid_ID;
                rs1_ex_d   = rs1_ID;
                rs2_ex_d   = rs2_ID;
                rdat1_ex_d = rdat1_ID;
                rdat2_ex_d = rdat2_ID;
                wsel_ex_d  = wsel_ID;
                // Writes to x0 or from non-instructions never reach the forwarding unit
                regwr_ex_d = RegWr_ID & valid_ID & (wsel_ID != '0);
                memrd_ex_d = MemRd_ID;
            end
            wsel_mem_d  = wsel_ex_q;
            regwr_mem_d = regwr_ex_q;
            memrd_mem_d = memrd_ex_q;
            alu_mem_d   = alu_result_EX;
            wsel_wb_d   = wsel_mem_q;
            regwr_wb_d  = regwr_mem_q;
            wdat_wb_d   = memrd_mem_q ? dmem_rdata_MEM : alu_mem_q;
            fwd_count_d = fwd_sum[CNT_W] ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
        end
    end

    // State register with synchronous active-low reset clearing every stage
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_ex_q  <= 1'b0;
            rs1_ex_q    <= '0;
            rs2_ex_q    <= '0;
            rdat1_ex_q  <= '0;
            rdat2_ex_q  <= '0;
            wsel_ex_q   <= '0;
            regwr_ex_q  <= 1'b0;
            memrd_ex_q  <= 1'b0;
            wsel_mem_q  <= '0;
            regwr_mem_q <= 1'b0;
            memrd_mem_q <= 1'b0;
            alu_mem_q   <= '0;
            wsel_wb_q   <= '0;
            regwr_wb_q  <= 1'b0;
            wdat_wb_q   <= '0;
            fwd_count_q <= '0;
        end else begin
            valid_ex_q  <= valid_ex_d;
            rs1_ex_q    <= rs1_ex_d;
            rs2_ex_q    <= rs2_ex_d;
            rdat1_ex_q  <= rdat1_ex_d;
            rdat2_ex_q  <= rdat2_ex_d;
            wsel_ex_q   <= wsel_ex_d;
            regwr_ex_q  <= regwr_ex_d;
            memrd_ex_q  <= memrd_ex_d;
            wsel_mem_q  <= wsel_mem_d;
            regwr_mem_q <= regwr_mem_d;
            memrd_mem_q <= memrd_mem_d;
            alu_mem_q   <= alu_mem_d;
            wsel_wb_q   <= wsel_wb_d;
            regwr_wb_q  <= regwr_wb_d;
            wdat_wb_q   <= wdat_wb_d;
            fwd_count_q <= fwd_count_d;
        end
    end

    assign rs1_EX    = rs1_ex_q;
    assign rs2_EX    = rs2_ex_q;
    assign wsel_MEM  = wsel_mem_q;
    assign RegWr_MEM = regwr_mem_q;
    assign wsel_WB   = wsel_wb_q;
    assign RegWr_WB  = regwr_wb_q;
    assign wdat_WB   = wdat_wb_q;
    assign lu_stall  = stall;
    assign fwd_count = fwd_count_q;

endmodule

// File: tb/tb_fwd_operand_pipe.sv
// Testbench for fwd_operand_pipe: directed scenarios plus a randomised run,
// with expected outputs from a behavioural model queued as a scoreboard.
module tb_fwd_operand_pipe;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              CLK;
    logic              nRST;
    logic              freeze;
    logic              flush_EX;
    logic              valid_ID;
    logic [REG_W-1:0]  rs1_ID, rs2_ID, wsel_ID;
    logic [DATA_W-1:0] rdat1_ID, rdat2_ID;
    logic              RegWr_ID, MemRd_ID;
    logic [DATA_W-1:0] alu_result_EX, dmem_rdata_MEM;
    logic [1:0]        ForwardA, ForwardB;
    logic [REG_W-1:0]  rs1_EX, rs2_EX, wsel_MEM, wsel_WB;
    logic              RegWr_MEM, RegWr_WB;
    logic [DATA_W-1:0] opA_EX, opB_EX, wdat_WB;
    logic              lu_stall;
    logic [CNT_W-1:0]  fwd_count;

    fwd_operand_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .freeze(freeze), .flush_EX(flush_EX),
        .valid_ID(valid_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rdat1_ID(rdat1_ID), .rdat2_ID(rdat2_ID), .wsel_ID(wsel_ID),
        .RegWr_ID(RegWr_ID), .MemRd_ID(MemRd_ID),
        .alu_result_EX(alu_result_EX), .dmem_rdata_MEM(dmem_rdata_MEM),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .wsel_MEM(wsel_MEM), .wsel_WB(wsel_WB),
        .RegWr_MEM(RegWr_MEM), .RegWr_WB(RegWr_WB),
        .opA_EX(opA_EX), .opB_EX(opB_EX), .wdat_WB(wdat_WB),
        .lu_stall(lu_stall), .fwd_count(fwd_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic        m_valid_ex, m_regwr_ex, m_memrd_ex;
    logic [4:0]  m_rs1_ex, m_rs2_ex, m_wsel_ex;
    logic [31:0] m_rdat1_ex, m_rdat2_ex;
    logic [4:0]  m_wsel_mem, m_wsel_wb;
    logic        m_regwr_mem, m_memrd_mem, m_regwr_wb;
    logic [31:0] m_alu_mem, m_wdat_wb;
    int          m_cnt;

    typedef struct {
        logic [4:0]  rs1, rs2, wm, ww;
        logic        rm, rw, lu;
        logic [31:0] a, b, wd;
        int          cnt;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic model_stall();
        return !freeze && m_valid_ex && m_memrd_ex && m_regwr_ex && valid_ID &&
               (m_wsel_ex == rs1_ID || m_wsel_ex == rs2_ID);
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rdat);
        if (s == 2'b10) return m_alu_mem;
        if (s == 2'b01) return m_wdat_wb;
        return rdat;
    endfunction

    task automatic model_clear();
        m_valid_ex = 0; m_regwr_ex = 0; m_memrd_ex = 0;
        m_rs1_ex = 0; m_rs2_ex = 0; m_wsel_ex = 0; m_rdat1_ex = 0; m_rdat2_ex = 0;
        m_wsel_mem = 0; m_regwr_mem = 0; m_memrd_mem = 0; m_alu_mem = 0;
        m_wsel_wb = 0; m_regwr_wb = 0; m_wdat_wb = 0; m_cnt = 0;
    endtask

    task automatic model_update();
        int inc;
        logic bubble;
        if (!nRST) begin
            model_clear();
        end else if (!freeze) begin
            inc = 0;
            if (m_valid_ex && (ForwardA == 2'b01 || ForwardA == 2'b10)) inc++;
            if (m_valid_ex && (ForwardB == 2'b01 || ForwardB == 2'b10)) inc++;
            m_cnt  = (m_cnt + inc > CNT_MAX) ? CNT_MAX : m_cnt + inc;
            bubble = flush_EX || model_stall();
            m_wsel_wb   = m_wsel_mem;
            m_regwr_wb  = m_regwr_mem;
            m_wdat_wb   = m_memrd_mem ? dmem_rdata_MEM : m_alu_mem;
            m_wsel_mem  = m_wsel_ex;
            m_regwr_mem = m_regwr_ex;
            m_memrd_mem = m_memrd_ex;
            m_alu_mem   = alu_result_EX;
            if (bubble) begin
                m_valid_ex = 0; m_regwr_ex = 0; m_memrd_ex = 0;
                m_rs1_ex = 0; m_rs2_ex = 0; m_wsel_ex = 0;
                m_rdat1_ex = 0; m_rdat2_ex = 0;
            end else begin
                m_valid_ex = valid_ID;
                m_rs1_ex   = rs1_ID;
                m_rs2_ex   = rs2_ID;
                m_wsel_ex  = wsel_ID;
                m_rdat1_ex = rdat1_ID;
                m_rdat2_ex = rdat2_ID;
                m_regwr_ex = RegWr_ID && valid_ID && (wsel_ID != 0);
                m_memrd_ex = MemRd_ID;
            end
        end
    endtask

    // One clock: queue expected outputs for the current inputs, compare the
    // DUT against the oldest queued entry, then advance DUT and model together.
    task automatic step();
        exp_t e;
        #1;
        e.rs1 = m_rs1_ex;   e.rs2 = m_rs2_ex;
        e.wm  = m_wsel_mem; e.ww  = m_wsel_wb;
        e.rm  = m_regwr_mem; e.rw = m_regwr_wb;
        e.lu  = model_stall();
        e.a   = pick(ForwardA, m_rdat1_ex);
        e.b   = pick(ForwardB, m_rdat2_ex);
        e.wd  = m_wdat_wb;
        e.cnt = m_cnt;
        sb_q.push_back(e);
        e = sb_q.pop_front();
        chk("rs1_EX", 32'(rs1_EX), 32'(e.rs1));
        chk("rs2_EX", 32'(rs2_EX), 32'(e.rs2));
        chk("wsel_MEM", 32'(wsel_MEM), 32'(e.wm));
        chk("wsel_WB", 32'(wsel_WB), 32'(e.ww));
        chk("RegWr_MEM", 32'(RegWr_MEM), 32'(e.rm));
        chk("RegWr_WB", 32'(RegWr_WB), 32'(e.rw));
        chk("lu_stall", 32'(lu_stall), 32'(e.lu));
        chk("opA_EX", opA_EX, e.a);
        chk("opB_EX", opB_EX, e.b);
        chk("wdat_WB", wdat_WB, e.wd);
        chk("fwd_count", 32'(fwd_count), 32'(e.cnt));
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic idle();
        nRST = 1; freeze = 0; flush_EX = 0; valid_ID = 0;
        rs1_ID = 0; rs2_ID = 0; wsel_ID = 0; rdat1_ID = 0; rdat2_ID = 0;
        RegWr_ID = 0; MemRd_ID = 0; alu_result_EX = 0; dmem_rdata_MEM = 0;
        ForwardA = 0; ForwardB = 0;
    endtask

    task automatic rand_inputs();
        freeze = ($urandom_range(0, 7) == 0);
        flush_EX = ($urandom_range(0, 7) == 0);
        valid_ID = 1'($urandom);
        rs1_ID = 5'($urandom_range(0, 3));
        rs2_ID = 5'($urandom_range(0, 3));
        wsel_ID = 5'($urandom_range(0, 3));
        rdat1_ID = $urandom; rdat2_ID = $urandom;
        RegWr_ID = 1'($urandom); MemRd_ID = 1'($urandom);
        alu_result_EX = $urandom; dmem_rdata_MEM = $urandom;
        ForwardA = 2'($urandom); ForwardB = 2'($urandom);
    endtask

    initial begin
        // Reset with random inputs; the first edge only initialises state
        idle();
        rand_inputs();
        nRST = 0;
        @(posedge CLK);
        model_clear();
        @(negedge CLK);
        repeat (2) begin
            rand_inputs();
            nRST = 0;
            step();
        end
        rand_inputs();
        freeze = 0;
        nRST = 0;
        #1;
        chk("rst_count", 32'(fwd_count), 32'd0);
        chk("rst_lu_stall", 32'(lu_stall), 32'd0);
        chk("rst_wdat", wdat_WB, 32'd0);
        chk("rst_opA", opA_EX, 32'd0);
        step();

        // First instruction after release
        idle();
        valid_ID = 1; wsel_ID = 5; RegWr_ID = 1; rs1_ID = 9; rs2_ID = 4;
        step();
        chk("first_rs1_EX", 32'(rs1_EX), 32'd9);
        idle();
        step();
        chk("first_wsel_MEM", 32'(wsel_MEM), 32'd5);
        chk("first_RegWr_MEM", 32'(RegWr_MEM), 32'd1);

        // EX->EX and MEM->EX forwarding, reserved select
        idle();
        valid_ID = 1; wsel_ID = 3; RegWr_ID = 1;
        step();
        idle();
        alu_result_EX = 32'h10;
        valid_ID = 1; rs1_ID = 3; rdat1_ID = 32'hDEAD;
        step();
        alu_result_EX = 32'h20;
        ForwardA = 2'b10;
        #1;
        chk("fwdA_10", opA_EX, 32'h10);
        chk("cnt_before", 32'(fwd_count), 32'd0);
        step();
        chk("cnt_after_10", 32'(fwd_count), 32'd1);
        ForwardA = 2'b01;
        #1;
        chk("fwdA_01", opA_EX, 32'h10);
        step();
        chk("cnt_after_01", 32'(fwd_count), 32'd2);
        ForwardA = 2'b11;
        #1;
        chk("fwdA_11", opA_EX, 32'hDEAD);
        step();
        chk("cnt_after_11", 32'(fwd_count), 32'd2);

        // Load-use hazard
        idle();
        valid_ID = 1; wsel_ID = 7; RegWr_ID = 1; MemRd_ID = 1; rs1_ID = 1;
        step();
        idle();
        valid_ID = 1; rs1_ID = 1; rs2_ID = 7; rdat2_ID = 32'h1234;
        #1;
        chk("lu_stall_on", 32'(lu_stall), 32'd1);
        step();
        chk("lu_bubble_rs2", 32'(rs2_EX), 32'd0);
        dmem_rdata_MEM = 32'hCAFE;
        #1;
        chk("lu_stall_once", 32'(lu_stall), 32'd0);
        step();
        chk("load_wdat_WB", wdat_WB, 32'hCAFE);
        chk("load_wsel_WB", 32'(wsel_WB), 32'd7);
        chk("load_RegWr_WB", 32'(RegWr_WB), 32'd1);
        chk("dep_rs2_EX", 32'(rs2_EX), 32'd7);

        // x0 write suppression
        idle();
        valid_ID = 1; wsel_ID = 0; RegWr_ID = 1;
        step();
        idle();
        step();
        chk("x0_RegWr_MEM", 32'(RegWr_MEM), 32'd0);

        // Flush
        idle();
        valid_ID = 1; wsel_ID = 4; RegWr_ID = 1; rs1_ID = 6; flush_EX = 1;
        step();
        chk("flush_rs1_EX", 32'(rs1_EX), 32'd0);
        idle();
        step();
        chk("flush_RegWr_MEM", 32'(RegWr_MEM), 32'd0);

        // Flush together with load-use: exactly one bubble
        idle();
        valid_ID = 1; wsel_ID = 8; RegWr_ID = 1; MemRd_ID = 1;
        step();
        idle();
        valid_ID = 1; rs1_ID = 8; flush_EX = 1;
        #1;
        chk("flush_lu_on", 32'(lu_stall), 32'd1);
        step();
        chk("flush_lu_bubble", 32'(rs1_EX), 32'd0);
        flush_EX = 0;
        #1;
        chk("flush_lu_single", 32'(lu_stall), 32'd0);
        step();
        chk("flush_lu_dep", 32'(rs1_EX), 32'd8);

        // Freeze with a dependent load in EX
        idle();
        valid_ID = 1; wsel_ID = 9; RegWr_ID = 1; MemRd_ID = 1; rs1_ID = 2;
        step();
        idle();
        valid_ID = 1; rs1_ID = 9; freeze = 1;
        ForwardA = 2'b10; ForwardB = 2'b10; alu_result_EX = 32'h77;
        repeat (3) begin
            #1;
            chk("frz_lu_stall", 32'(lu_stall), 32'd0);
            step();
            chk("frz_rs1_EX", 32'(rs1_EX), 32'd2);
            chk("frz_count", 32'(fwd_count), 32'd2);
        end
        freeze = 0; ForwardA = 0; ForwardB = 0;
        #1;
        chk("unfrz_lu_stall", 32'(lu_stall), 32'd1);
        step();

        // Counter saturation
        idle();
        valid_ID = 1; ForwardA = 2'b10; ForwardB = 2'b10;
        repeat (10) step();
        chk("sat_count", 32'(fwd_count), 32'(CNT_MAX));
        step();
        chk("sat_hold", 32'(fwd_count), 32'(CNT_MAX));

        // Randomised traffic including occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            nRST = ($urandom_range(0, 31) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
